// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Access cannot be issued: natural alignment broken or size code illegal.
  function automatic logic misaligned(size_e size, logic [1:0] a);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  // Right-aligned byte enables for a store of the given size.
  function automatic logic [3:0] size_mask(size_e size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = MASK_B;
      SZ_H:    m = MASK_H;
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extension: picks byte/half/word from right-aligned memory data
// and sign- or zero-extends it to 32 bits.
import lsu_pkg::*;

module lsu_load_ext (
  input  logic [31:0] data_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  // Extension select; word loads pass through regardless of signedness.
  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_B:    data_o = {{24{~unsigned_i & data_i[7]}},  data_i[7:0]};
      SZ_H:    data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one load/store at a time, checks alignment,
// issues a one-cycle memory request and returns the extended result.
// Optional LSU_TIMEOUT_EN: abandons a wait after TIMEOUT_CYCLES with an error.
import lsu_pkg::*;

module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        read_req_valid_o,
  output logic [31:0] read_req_addr_o,
  input  logic        read_res_valid_i,
  input  logic [31:0] read_res_data_i,
  output logic        write_req_valid_o,
  output logic [31:0] write_req_addr_o,
  output logic [31:0] write_req_data_o,
  output logic [3:0]  write_req_mask_o,
  input  logic        write_res_valid_i
);

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        wr_vld_q, wr_vld_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_mask_q, wr_mask_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] ld_data;
  size_e       cmd_size;

  assign cmd_size = size_e'(cmd_size_i);

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  lsu_load_ext u_ext (
    .data_i     (read_res_data_i),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  // Next state and registered outputs; request/response strobes default low.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_vld_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_vld_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_mask_d   = wr_mask_q;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (misaligned(cmd_size, cmd_addr_i[1:0])) begin
            rsp_vld_d = 1'b1;
            rsp_err_d = 1'b1;
          end else if (cmd_we_i) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = cmd_addr_i;
            wr_data_d = cmd_wdata_i;
            wr_mask_d = size_mask(cmd_size);
            state_d   = WR_WAIT;
          end else begin
            rd_vld_d  = 1'b1;
            rd_addr_d = cmd_addr_i;
            size_d    = cmd_size;
            uns_d     = cmd_unsigned_i;
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (read_res_valid_i) begin
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = ld_data;
          state_d     = IDLE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (expired) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WR_WAIT: begin
        if (write_res_valid_i) begin
          rsp_vld_d = 1'b1;
          state_d   = IDLE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (expired) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= 32'h0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= 32'h0;
      wr_data_q   <= 32'h0;
      wr_mask_q   <= 4'h0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_mask_q   <= wr_mask_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign cmd_ready_o       = rst_ni & (state_q == IDLE);
  assign rsp_valid_o       = rsp_vld_q;
  assign rsp_err_o         = rsp_err_q;
  assign rsp_rdata_o       = rsp_rdata_q;
  assign read_req_valid_o  = rd_vld_q;
  assign read_req_addr_o   = rd_addr_q;
  assign write_req_valid_o = wr_vld_q;
  assign write_req_addr_o  = wr_addr_q;
  assign write_req_data_o  = wr_data_q;
  assign write_req_mask_o  = wr_mask_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a one-cycle-latency memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_uns;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rreq_v, rres_v, wreq_v, wres_v;
  logic [31:0] rreq_a, rres_d, wreq_a, wreq_d;
  logic [3:0]  wreq_m;

  logic        mem_en, mem_rv, mem_wv, inj_rv;
  logic [31:0] mem_rd, inj_rd;
  logic [31:0] mem [0:255];
  int          rd_req_cnt;
  int          errs = 0, checks = 0;
  int          lat;

  always #5 clk = ~clk;

  assign rres_v = mem_rv | inj_rv;
  assign rres_d = inj_rv ? inj_rd : mem_rd;
  assign wres_v = mem_wv;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_size_i(cmd_size),
    .cmd_unsigned_i(cmd_uns),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .read_req_valid_o(rreq_v), .read_req_addr_o(rreq_a),
    .read_res_valid_i(rres_v), .read_res_data_i(rres_d),
    .write_req_valid_o(wreq_v), .write_req_addr_o(wreq_a),
    .write_req_data_o(wreq_d), .write_req_mask_o(wreq_m),
    .write_res_valid_i(wres_v)
  );

  // Memory model: answers one cycle after a request, data right-aligned.
  always @(posedge clk) begin
    mem_rv <= 1'b0;
    mem_wv <= 1'b0;
    if (rreq_v) rd_req_cnt <= rd_req_cnt + 1;
    if (mem_en && rreq_v) begin
      mem_rv <= 1'b1;
      mem_rd <= mem[rreq_a[9:2]] >> (8 * rreq_a[1:0]);
    end
    if (mem_en && wreq_v) begin
      logic [3:0]  m;
      logic [31:0] d;
      m = wreq_m << wreq_a[1:0];
      d = wreq_d << (8 * wreq_a[1:0]);
      for (int k = 0; k < 4; k++)
        if (m[k]) mem[wreq_a[9:2]][8*k +: 8] <= d[8*k +: 8];
      mem_wv <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Present a command at a negedge; returns at the negedge of T+1 with valid dropped.
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic un);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
    cmd_size = sz; cmd_uns = un;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF; cmd_size = 2'd0; cmd_uns = ~un;
  endtask

  // Count cycles from T+1 (=1) until rsp_valid is seen; 0 if never within bound.
  task automatic await_rsp(output int l);
    l = 0;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid) begin l = i; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h80AA55CC;
    mem[8'h80] = 32'h11223344;
    mem_en = 1'b1; inj_rv = 1'b0; inj_rd = 32'h0; rd_req_cnt = 0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    cmd_size = 2'd0; cmd_uns = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset rreq_a", rreq_a, 32'h0);
    chk("reset wreq_m", {28'h0, wreq_m}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready idle", {31'h0, cmd_ready}, 32'h1);

    // 1: signed byte load
    send(1'b0, 32'h103, 32'h0, 2'd0, 1'b0);
    chk("t1 rreq_v", {31'h0, rreq_v}, 32'h1);
    chk("t1 rreq_a", rreq_a, 32'h103);
    chk("t1 ready busy", {31'h0, cmd_ready}, 32'h0);
    await_rsp(lat);
    chk("t1 latency", lat, 32'd3);
    chk("t1 rdata", rsp_rdata, 32'hFFFFFF80);
    chk("t1 err", {31'h0, rsp_err}, 32'h0);
    chk("t1 ready", {31'h0, cmd_ready}, 32'h1);

    // 2: half store then word read of the same word
    send(1'b1, 32'h202, 32'h0000BEEF, 2'd1, 1'b0);
    chk("t2 wreq_v", {31'h0, wreq_v}, 32'h1);
    chk("t2 wreq_m", {28'h0, wreq_m}, 32'h3);
    chk("t2 wreq_d", wreq_d, 32'h0000BEEF);
    chk("t2 wreq_a", wreq_a, 32'h202);
    await_rsp(lat);
    chk("t2 latency", lat, 32'd3);
    chk("t2 rdata", rsp_rdata, 32'h0);
    send(1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
    await_rsp(lat);
    chk("t2 readback", rsp_rdata, 32'hBEEF3344);

    // 3: misaligned word, misaligned half, illegal size
    begin
      int c0;
      c0 = rd_req_cnt;
      send(1'b0, 32'h101, 32'h0, 2'd2, 1'b0);
      chk("t3 rsp T+1", {31'h0, rsp_valid}, 32'h1);
      chk("t3 err", {31'h0, rsp_err}, 32'h1);
      chk("t3 rdata", rsp_rdata, 32'h0);
      send(1'b0, 32'h201, 32'h0, 2'd1, 1'b0);
      chk("t3 half err", {30'h0, rsp_valid, rsp_err}, 32'h3);
      send(1'b1, 32'h200, 32'h0, 2'd3, 1'b0);
      chk("t3 size3 err", {30'h0, rsp_valid, rsp_err}, 32'h3);
      chk("t3 no wreq", {31'h0, wreq_v}, 32'h0);
      repeat (3) @(negedge clk);
      chk("t3 no rreq", rd_req_cnt - c0, 32'd0);
    end

    // extension variants
    send(1'b0, 32'h102, 32'h0, 2'd1, 1'b1);
    await_rsp(lat);
    chk("ld hu", rsp_rdata, 32'h000080AA);
    send(1'b0, 32'h102, 32'h0, 2'd1, 1'b0);
    await_rsp(lat);
    chk("ld h", rsp_rdata, 32'hFFFF80AA);
    send(1'b0, 32'h103, 32'h0, 2'd0, 1'b1);
    await_rsp(lat);
    chk("ld bu", rsp_rdata, 32'h00000080);
    send(1'b0, 32'h101, 32'h0, 2'd0, 1'b0);
    await_rsp(lat);
    chk("ld b pos", rsp_rdata, 32'h00000055);
    send(1'b1, 32'h401, 32'hFFFFFFA5, 2'd0, 1'b0);
    chk("st b mask", {28'h0, wreq_m}, 32'h1);
    await_rsp(lat);
    send(1'b0, 32'h400, 32'h0, 2'd2, 1'b0);
    await_rsp(lat);
    chk("st b readback", rsp_rdata, 32'h0000A500);

    // 4: back-to-back store word then load word, valid held
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'hCAFEF00D;
    cmd_size = 2'd2; cmd_uns = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_we = 1'b0; cmd_wdata = 32'h0;
    chk("t4 wreq_v", {31'h0, wreq_v}, 32'h1);
    @(negedge clk);
    chk("t4 busy T+2", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("t4 st rsp", {30'h0, rsp_valid, rsp_err}, 32'h2);
    chk("t4 ready in rsp", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 32'h0;
    chk("t4 ld rreq", {31'h0, rreq_v}, 32'h1);
    chk("t4 ld addr", rreq_a, 32'h300);
    await_rsp(lat);
    chk("t4 ld lat", lat, 32'd3);
    chk("t4 ld data", rsp_rdata, 32'hCAFEF00D);

    // 5: silent memory
    mem_en = 1'b0;
    send(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
`ifdef LSU_TIMEOUT_EN
    await_rsp(lat);
    chk("t5 timeout lat", lat, 32'd5);
    chk("t5 timeout err", {31'h0, rsp_err}, 32'h1);
    chk("t5 timeout rdata", rsp_rdata, 32'h0);
    inj_rv = 1'b1; inj_rd = 32'h12345678;
    @(negedge clk);
    inj_rv = 1'b0;
    @(negedge clk);
    chk("t5 stale ignored", {31'h0, rsp_valid}, 32'h0);
`else
    repeat (20) @(negedge clk);
    chk("t5 still waiting", {31'h0, rsp_valid | cmd_ready}, 32'h0);
    inj_rv = 1'b1; inj_rd = 32'h12345678;
    @(negedge clk);
    inj_rv = 1'b0;
    chk("t5 late rsp", {30'h0, rsp_valid, rsp_err}, 32'h2);
    chk("t5 late data", rsp_rdata, 32'h12345678);
`endif

    // 6: reset in RD_WAIT
    send(1'b0, 32'h104, 32'h0, 2'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6 rreq_v", {31'h0, rreq_v}, 32'h0);
    chk("t6 rreq_a", rreq_a, 32'h0);
    chk("t6 outs", {rsp_valid, rsp_err, wreq_v, cmd_ready, wreq_m} | rsp_rdata | wreq_a | wreq_d, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    inj_rv = 1'b1; inj_rd = 32'h0BAD0BAD;
    @(negedge clk);
    inj_rv = 1'b0;
    chk("t6 no rsp", {31'h0, rsp_valid}, 32'h0);
    chk("t6 idle", {31'h0, cmd_ready}, 32'h1);
    mem_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
